pc_seq: RTL

- Parametrised next-generation program counter for the core fetch stage.
- Adds to the plain increment/absolute-jump PC:
  - signed relative branch
  - stall
  - call/return via a circular return-address stack (RAS)
  - a one-cycle start-up hold after reset
- Drives prog_ctr straight to instruction memory.

---
 rtl/pc_pkg.sv | 24 ++
 rtl/pc_ras.sv | 64 ++++++
 rtl/pc_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer.
package pc_pkg;

  // Next-PC source, listed in decreasing priority.
  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_RET,
    SEL_CALL,
    SEL_ABS,
    SEL_REL,
    SEL_INC
  } pc_sel_t;

  // Sign-extend the low w bits of v to 32 bits (1 <= w <= 32).
  function automatic logic [31:0] sext(input logic [31:0] v, input int unsigned w);
    logic [31:0] r;
    r = v;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i >= w) r[i] = v[w-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push into a full stack overwrites the
// oldest entry and pulses ovf_o; a pop from an empty stack pulses udf_o.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned D         = 12,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [D-1:0] push_data_i,
  output logic [D-1:0] top_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         ovf_o,
  output logic         udf_o
);

  localparam int unsigned AW = $clog2(RAS_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(RAS_DEPTH);

  logic [D-1:0]  mem_q [RAS_DEPTH];
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign ovf_o   = push_i && full_o;
  assign udf_o   = pop_i && empty_o;
  // ptr_q points at the next free slot, so the newest entry sits just below it.
  assign top_o   = mem_q[ptr_q - 1'b1];

  // Pointer and occupancy update; a full push wraps onto the oldest slot.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + 1'b1;
      if (!full_o) cnt_d = cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Stack bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are meaningless while unoccupied, so no reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/pc_seq.sv
// Program counter for the fetch stage: increment, absolute and relative
// jumps, stall, one-cycle start-up hold, and call/return through a
// return-address stack when PC_RAS_EN is defined. Without PC_RAS_EN,
// call_en acts as an absolute jump and ret_en is ignored.
module pc_seq
  import pc_pkg::*;
#(
  parameter int unsigned  D         = 12,
  parameter int unsigned  OFFSET_W  = 8,
  parameter int unsigned  RAS_DEPTH = 4,
  parameter logic [D-1:0] RESET_VEC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                absjump_en,
  input  logic                reljump_en,
  input  logic [OFFSET_W-1:0] offset,
  input  logic                call_en,
  input  logic                ret_en,
  input  logic [D-1:0]        target,
  output logic [D-1:0]        prog_ctr,
  output logic                ras_empty,
  output logic                ras_full,
  output logic                ras_err
);

  logic [D-1:0] pc_q, pc_d;
  logic [D-1:0] pc_inc, pc_rel, ret_pc;
  logic [31:0]  off_ext;
  logic         unused_ext;
  logic         started_q;
  pc_sel_t      sel;

  assign off_ext    = sext(32'(offset), OFFSET_W);
  assign unused_ext = ^off_ext;
  assign pc_inc     = pc_q + 1'b1;
  assign pc_rel     = pc_q + off_ext[D-1:0];
  assign prog_ctr   = pc_q;

`ifdef PC_RAS_EN
  logic [D-1:0] ras_top;
  logic         ras_empty_w, ras_full_w, ras_ovf, ras_udf;
  logic         err_q;

  pc_ras #(
    .D         (D),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (sel == SEL_CALL),
    .pop_i       (sel == SEL_RET),
    .push_data_i (pc_inc),
    .top_o       (ras_top),
    .empty_o     (ras_empty_w),
    .full_o      (ras_full_w),
    .ovf_o       (ras_ovf),
    .udf_o       (ras_udf)
  );

  // Underflowing return still advances sequentially.
  assign ret_pc    = ras_empty_w ? pc_inc : ras_top;
  assign ras_empty = ras_empty_w;
  assign ras_full  = ras_full_w;
  assign ras_err   = err_q;

  // Sticky stack-error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else if (ras_ovf || ras_udf) err_q <= 1'b1;
  end
`else
  logic unused_ret;
  assign unused_ret = ret_en;
  assign ret_pc     = pc_inc;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
  assign ras_err    = 1'b0;
`endif

  // Priority select of the next-PC source.
  always_comb begin
    sel = SEL_INC;
    if (!started_q || stall) sel = SEL_HOLD;
`ifdef PC_RAS_EN
    else if (ret_en)         sel = SEL_RET;
`endif
    else if (call_en)        sel = SEL_CALL;
    else if (absjump_en)     sel = SEL_ABS;
    else if (reljump_en)     sel = SEL_REL;
  end

  // Next-PC mux.
  always_comb begin
    pc_d = pc_q;
    case (sel)
      SEL_RET:  pc_d = ret_pc;
      SEL_CALL: pc_d = target;
      SEL_ABS:  pc_d = target;
      SEL_REL:  pc_d = pc_rel;
      SEL_INC:  pc_d = pc_inc;
      default:  pc_d = pc_q;
    endcase
  end

  // PC and start-up hold registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_VEC;
      started_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      started_q <= 1'b1;
    end
  end

endmodule
